// File: rtl/cpu0_bus_pkg.sv
// rtl/cpu0_bus_pkg.sv - shared CPU0 memory bus constants, state encoding and range helper
package cpu0_bus_pkg;

    localparam int   WORD_W   = 32;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // A word at addr occupies addr..addr+3; widen to 33 bits so the top of the
    // 32-bit space cannot wrap back into range.
    function automatic logic word_in_range(input logic [WORD_W-1:0] addr,
                                           input int unsigned depth_bytes);
        return ({1'b0, addr} + 33'd3) <= {1'b0, depth_bytes - 32'd1};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU0 memory bus request/response bundle
interface mem_responder_if;
    import cpu0_bus_pkg::*;

    logic              en;
    logic              rw;
    logic [WORD_W-1:0] abus;
    logic [WORD_W-1:0] dbus_in;
    logic [WORD_W-1:0] dbus_out;
    logic              ready;
    logic              err;

    modport master (
        output en, rw, abus, dbus_in,
        input  dbus_out, ready, err
    );

    modport slave (
        input  en, rw, abus, dbus_in,
        output dbus_out, ready, err
    );

endinterface

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - byte storage with one big-endian word read port and one word write port
module mem_byte_array
    import cpu0_bus_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Contents are deliberately not reset so preloaded programs survive a reset.
    logic [7:0] mem_q [DEPTH_BYTES];

    logic [AW-1:0] wa1, wa2, wa3;
    logic [AW-1:0] ra1, ra2, ra3;

    // Callers only use the ports for in-range words, so a+3 never overflows AW.
    assign wa1 = waddr_i + AW'(1);
    assign wa2 = waddr_i + AW'(2);
    assign wa3 = waddr_i + AW'(3);
    assign ra1 = raddr_i + AW'(1);
    assign ra2 = raddr_i + AW'(2);
    assign ra3 = raddr_i + AW'(3);

    // Most-significant byte lands at the lowest address.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i[31:24];
            mem_q[wa1]     <= wdata_i[23:16];
            mem_q[wa2]     <= wdata_i[15:8];
            mem_q[wa3]     <= wdata_i[7:0];
        end
    end

    assign rdata_o = {mem_q[raddr_i], mem_q[ra1], mem_q[ra2], mem_q[ra3]};

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the CPU0 bus with side-band loader
module mem_responder
    import cpu0_bus_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic              ld_we,
    input  logic [WORD_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data
);

    localparam int AW = $clog2(DEPTH_BYTES);

    mem_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [WORD_W-1:0] addr_q;
    logic              rw_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;

    logic              in_range_d;
    logic              ld_ok_d;
    logic              ld_hit_d;
    logic              commit_d;
    logic              mem_we_d;
    logic [AW-1:0]     mem_waddr_d;
    logic [WORD_W-1:0] mem_wdata_d;
    logic [WORD_W-1:0] mem_rdata_d;

    assign in_range_d = word_in_range(addr_q, DEPTH_BYTES);
    assign ld_ok_d    = word_in_range(ld_addr, DEPTH_BYTES);

    // Loader only acts in IDLE; the bus write commits on the final WAIT cycle.
    assign ld_hit_d    = (state_q == IDLE) && ld_we;
    assign commit_d    = (state_q == WAIT) && (cnt_q == 4'd0) &&
                         (rw_q == RW_WRITE) && in_range_d;
    assign mem_we_d    = (ld_hit_d && ld_ok_d) || commit_d;
    assign mem_waddr_d = ld_hit_d ? ld_addr[AW-1:0] : addr_q[AW-1:0];
    assign mem_wdata_d = ld_hit_d ? ld_data : wdata_q;

    mem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .we_i    (mem_we_d),
        .waddr_i (mem_waddr_d),
        .wdata_i (mem_wdata_d),
        .raddr_i (addr_q[AW-1:0]),
        .rdata_o (mem_rdata_d)
    );

    // Request FSM: accept in IDLE, count wait states, access, then a one-cycle response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ld_we && bus.en) begin
                        addr_q  <= bus.abus;
                        rw_q    <= bus.rw;
                        wdata_q <= bus.dbus_in;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= !in_range_d;
                        if (rw_q == RW_READ) begin
                            rdata_q <= in_range_d ? mem_rdata_d : '0;
                        end
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dbus_out = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder at 0, 1 and 3 wait states
module tb_mem_responder;
    import cpu0_bus_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [2:0]  en_v;
    logic        rw_v;
    logic [31:0] abus_v;
    logic [31:0] din_v;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  rdy;
    logic [2:0]  erv;
    logic [31:0] dout [3];

    int checks = 0;
    int errors = 0;
    int hits;

    mem_responder_if bus0();
    mem_responder_if bus1();
    mem_responder_if bus2();

    assign bus0.en = en_v[0]; assign bus0.rw = rw_v; assign bus0.abus = abus_v; assign bus0.dbus_in = din_v;
    assign bus1.en = en_v[1]; assign bus1.rw = rw_v; assign bus1.abus = abus_v; assign bus1.dbus_in = din_v;
    assign bus2.en = en_v[2]; assign bus2.rw = rw_v; assign bus2.abus = abus_v; assign bus2.dbus_in = din_v;

    assign rdy[0] = bus0.ready; assign erv[0] = bus0.err; assign dout[0] = bus0.dbus_out;
    assign rdy[1] = bus1.ready; assign erv[1] = bus1.err; assign dout[1] = bus1.dbus_out;
    assign rdy[2] = bus2.ready; assign erv[2] = bus2.err; assign dout[2] = bus2.dbus_out;

    mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .reset(reset), .bus(bus0.slave),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
    mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(1)) u_w1 (
        .clock(clock), .reset(reset), .bus(bus1.slave),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
    mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(3)) u_w3 (
        .clock(clock), .reset(reset), .bus(bus2.slave),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // One request on instance i; lat counts edges from acceptance to the ready cycle.
    task automatic do_req(input string tag, input int i, input logic r,
                          input logic [31:0] a, input logic [31:0] d, input int lat,
                          input logic hold, input logic [31:0] exp_q, input logic exp_e);
        int n;
        rw_v = r; abus_v = a; din_v = d; en_v[i] = 1'b1;
        tick();
        if (!hold) begin
            rw_v = ~r; abus_v = a ^ 32'h40; din_v = ~d;
        end
        n = 0;
        while (rdy[i] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".lat"},  32'(n), 32'(lat));
        check({tag, ".err"},  32'(erv[i]), 32'(exp_e));
        check({tag, ".data"}, dout[i], exp_q);
        if (!hold) en_v[i] = 1'b0;
        tick();
        check({tag, ".pulse"}, {30'b0, rdy[i], erv[i]}, 32'h0);
    endtask

    initial begin
        en_v = 3'b000; rw_v = RW_READ; abus_v = '0; din_v = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        reset = 1'b1;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset.ready%0d", k), 32'(rdy[k]), 32'h0);
            check($sformatf("reset.err%0d", k),   32'(erv[k]), 32'h0);
            check($sformatf("reset.dout%0d", k),  dout[k], 32'h0);
        end
        reset = 1'b0;
        tick();

        load(32'h00, 32'h001F0018);
        load(32'h24, 32'h00000000);
        load(32'hFC, 32'hA5A55AA5);
        load(32'h10, 32'hCAFEF00D);
        load(32'h30, 32'h11111111);

        do_req("ld_rd", 1, RW_READ, 32'h00, 32'h0, 2, 1'b0, 32'h001F0018, 1'b0);

        do_req("wr20",  0, RW_WRITE, 32'h20, 32'hDEADBEEF, 1, 1'b0, 32'h00000000, 1'b0);
        do_req("rd20",  0, RW_READ,  32'h20, 32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req("rd21",  0, RW_READ,  32'h21, 32'h0, 1, 1'b0, 32'hADBEEF00, 1'b0);

        do_req("oor_rd", 0, RW_READ,  32'h000000FD, 32'h0, 1, 1'b0, 32'h00000000, 1'b1);
        do_req("oor_wr", 0, RW_WRITE, 32'hFFFFFFFF, 32'h1, 1, 1'b0, 32'h00000000, 1'b1);
        do_req("rdFC",   0, RW_READ,  32'h000000FC, 32'h0, 1, 1'b0, 32'hA5A55AA5, 1'b0);
        do_req("rd00",   0, RW_READ,  32'h00000000, 32'h0, 1, 1'b0, 32'h001F0018, 1'b0);

        do_req("held1", 1, RW_READ, 32'h00, 32'h0, 2, 1'b1, 32'h001F0018, 1'b0);
        do_req("held2", 1, RW_READ, 32'h00, 32'h0, 2, 1'b0, 32'h001F0018, 1'b0);

        rw_v = RW_WRITE; abus_v = 32'h10; din_v = 32'h12345678; en_v[2] = 1'b1;
        tick();
        en_v[2] = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            if (rdy[2] !== 1'b0 || erv[2] !== 1'b0) hits++;
            tick();
        end
        check("rst_mid.noready", 32'(hits), 32'h0);
        do_req("rst_mid.rd", 2, RW_READ, 32'h10, 32'h0, 4, 1'b0, 32'hCAFEF00D, 1'b0);

        ld_we = 1'b1; ld_addr = 32'h30; ld_data = 32'h0BADCAFE;
        rw_v = RW_READ; abus_v = 32'h30; en_v[1] = 1'b1;
        tick();
        ld_we = 1'b0;
        check("coll.idle", 32'(rdy[1]), 32'h0);
        do_req("coll", 1, RW_READ, 32'h30, 32'h0, 2, 1'b0, 32'h0BADCAFE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synchronous, byte-addressed, big-endian word memory that answers the CPU0 memory bus: en, rw, address bus, write-data bus, read-data bus.
- Replaces the zero-latency behavioural memory. Adds a programmable wait-state count, a ready/err handshake and a side-band loader port so benches can preload programs.
- Sits in the computer top level between the cpu mar/mdr/m_en/m_rw outputs and the cpu dbus input.

Parameters:
- DEPTH_BYTES, 256, storage size in bytes (multiple of 4, at least 16).
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  request valid. Level signal, held by the initiator until ready.
- rw  in  1  1 = read, 0 = write. Sampled with en.
- abus  in  32  byte address of the word's most-significant byte.
- dbus_in  in  32  write data.
- dbus_out  out  32  read data.
- ready  out  1  one-cycle response strobe.
- err  out  1  valid with ready; request was out of range, no access performed.
- ld_we  in  1  loader write enable.
- ld_addr  in  32  loader byte address (word-granular).
- ld_data  in  32  loader word, big-endian.

Behaviour:
- Reset values: state=IDLE, ready=0, err=0, dbus_out=32'h0, wait counter=0.
- Memory contents are NOT cleared by reset.
- States:
  - IDLE
    - If ld_we=1: write ld_data to bytes ld_addr..ld_addr+3, big-endian; silently ignored if out of range. Loader has priority over en that cycle. An en held high is accepted on a later IDLE cycle.
    - Else if en=1: latch abus, rw, dbus_in; load counter=WAIT_CYCLES; go to WAIT.
  - WAIT
    - Counter nonzero: decrement.
    - Counter zero: perform the access and go to RESP.
    - Range check: abus+3 <= DEPTH_BYTES-1, computed in 33 bits so 32'hFFFFFFFD..FFFFFFFF do not wrap.
    - In range, read: dbus_out <= {m[a],m[a+1],m[a+2],m[a+3]}.
    - In range, write: commit latched data to the same 4 bytes.
    - Out of range: no memory change; dbus_out <= 32'h0; err flagged.
    - ld_we is ignored in WAIT and RESP.
  - RESP
    - ready=1 (and err if flagged) for exactly this cycle, then return to IDLE.
- Latency: ready is high in the cycle WAIT_CYCLES+1 cycles after the acceptance edge. With WAIT_CYCLES=0, ready is high the cycle after acceptance.
- Unaligned addresses (abus[1:0]!=0) are legal: bytes a..a+3, no wrap.
- dbus_out holds the last read (or error) value until the next read completes. Writes and errors-on-write do not alter dbus_out.
- Initiator rule: deassert en on the same edge that samples ready=1. en still high in the IDLE cycle after RESP is treated as a new request.
- Changes to abus/rw/dbus_in after acceptance are ignored (values latched).
- Reset mid-operation: state returns to IDLE within that edge. A pending write not yet committed is discarded. ready/err drop to 0.
- err is only ever high together with ready.

Decomposition:
- Shared package cpu0_bus_pkg holds:
  - RW_READ=1'b1, RW_WRITE=1'b0;
  - the state encoding IDLE/WAIT/RESP;
  - the 32-bit word width constant, also used by the cpu.
- Natural sub-module: mem_byte_array, the DEPTH_BYTES x 8 storage with one 4-byte big-endian read port and one 4-byte write port.
- The responder FSM, counter, range check and loader muxing stay in mem_responder.

Test Plan:
- Loader then read, WAIT_CYCLES=1:
  - Stimulus: load 32'h001F0018 at 0; read abus=0.
  - Response: ready exactly 2 cycles after acceptance; dbus_out=32'h001F0018; err=0.
- Write then read, WAIT_CYCLES=0:
  - Stimulus: write 32'hDEADBEEF at 0x20; read 0x20; then read 0x21.
  - Response: first read returns 32'hDEADBEEF. Read at 0x21 returns 32'hADBEEF00 (0x24 was preloaded 0); each ready 1 cycle after acceptance.
- Out of range, DEPTH_BYTES=256:
  - Stimulus: read 0xFD; write 0xFFFFFFFF with data 1.
  - Response: both give ready=1, err=1, dbus_out=0. Memory bytes 0xFC..0xFF unchanged.
- Held en / back-to-back:
  - Stimulus: en kept high for one extra cycle after ready.
  - Response: a second identical read is accepted and completes; ready pulses are never wider than 1 cycle.
- Reset mid-write, WAIT_CYCLES=3:
  - Stimulus: write 32'h12345678 at 0x10; assert reset at counter=1.
  - Response: no ready; a subsequent read of 0x10 returns the old contents.
- Loader/request collision:
  - Stimulus: ld_we and en both high in IDLE.
  - Response: load performed first; request accepted the next cycle. It returns the freshly loaded word if the addresses match.
